// File: rtl/seq_controller.sv
// Moore control FSM for the simple RISC datapath: fetch, decode, execute, memory, writeback.
// Optional macro SEQ_HALT_INSTR_EN adds a HALT instruction (opcode 111) that sticks until reset.
module seq_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       loadPC,
  output logic       loadIR,
  output logic       msel,
  output logic       mwrite,
  output logic       write,
  output logic       asel,
  output logic       bsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic [3:0] vsel,
  output logic [2:0] nsel,
  output logic       halted
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_IF1   = 4'd1;
  localparam logic [3:0] S_IF2   = 4'd2;
  localparam logic [3:0] S_UPD   = 4'd3;
  localparam logic [3:0] S_DEC   = 4'd4;
  localparam logic [3:0] S_WIMM  = 4'd5;
  localparam logic [3:0] S_GETA  = 4'd6;
  localparam logic [3:0] S_GETB  = 4'd7;
  localparam logic [3:0] S_EXEC  = 4'd8;
  localparam logic [3:0] S_WBC   = 4'd9;
  localparam logic [3:0] S_ADDR  = 4'd10;
  localparam logic [3:0] S_MRD   = 4'd11;
  localparam logic [3:0] S_LDWB  = 4'd12;
  localparam logic [3:0] S_MWR   = 4'd13;
`ifdef SEQ_HALT_INSTR_EN
  localparam logic [3:0] S_HALT  = 4'd14;
`endif

  logic [3:0] state, nxt;
  logic       is_movr, is_cmp, is_str, is_mem;
  logic [4:0] ir_op;

  assign ir_op = {opcode, op};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RESET;
    else       state <= nxt;
  end

  // Instruction class is captured in DEC so IR changes later are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_movr <= 1'b0;
      is_cmp  <= 1'b0;
      is_str  <= 1'b0;
      is_mem  <= 1'b0;
    end else if (state == S_DEC) begin
      is_movr <= (ir_op == 5'b110_00);
      is_cmp  <= (ir_op == 5'b101_01);
      is_str  <= (ir_op == 5'b100_00);
      is_mem  <= (ir_op == 5'b100_00) || (ir_op == 5'b011_00);
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_RESET: nxt = S_IF1;
      S_IF1:   nxt = S_IF2;
      S_IF2:   nxt = S_UPD;
      S_UPD:   nxt = S_DEC;
      S_DEC: begin
        case (ir_op)
          5'b110_10: nxt = S_WIMM;
          5'b110_00: nxt = S_GETB;
          5'b101_00,
          5'b101_01,
          5'b101_10,
          5'b101_11: nxt = S_GETA;
          5'b011_00,
          5'b100_00: nxt = S_GETA;
          default:   nxt = S_IF1;
        endcase
`ifdef SEQ_HALT_INSTR_EN
        if (opcode == 3'b111) nxt = S_HALT;
`endif
      end
      S_WIMM:  nxt = S_IF1;
      S_GETA:  nxt = is_mem ? S_ADDR : S_GETB;
      S_GETB:  nxt = is_str ? S_MWR : S_EXEC;
      S_EXEC:  nxt = is_cmp ? S_IF1 : S_WBC;
      S_WBC:   nxt = S_IF1;
      S_ADDR:  nxt = is_str ? S_GETB : S_MRD;
      S_MRD:   nxt = S_LDWB;
      S_LDWB:  nxt = S_IF1;
      S_MWR:   nxt = S_IF1;
`ifdef SEQ_HALT_INSTR_EN
      S_HALT:  nxt = S_HALT;
`endif
      default: nxt = S_RESET;
    endcase
  end

  always_comb begin
    loadPC = 1'b0;
    loadIR = 1'b0;
    msel   = 1'b0;
    mwrite = 1'b0;
    write  = 1'b0;
    asel   = 1'b0;
    bsel   = 1'b0;
    loada  = 1'b0;
    loadb  = 1'b0;
    loadc  = 1'b0;
    loads  = 1'b0;
    vsel   = 4'b0000;
    nsel   = 3'b000;
    case (state)
      S_IF2:  loadIR = 1'b1;
      S_UPD:  loadPC = 1'b1;
      S_WIMM: begin
        nsel  = 3'b100;
        vsel  = 4'b0100;
        write = 1'b1;
      end
      S_GETA: begin
        nsel  = 3'b100;
        loada = 1'b1;
      end
      S_GETB: begin
        nsel  = is_str ? 3'b010 : 3'b001;
        loadb = 1'b1;
      end
      S_EXEC: begin
        asel  = is_movr;
        loadc = 1'b1;
        loads = is_cmp;
      end
      S_WBC: begin
        nsel  = 3'b010;
        vsel  = 4'b0001;
        write = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_MRD:  msel = 1'b1;
      S_LDWB: begin
        msel  = 1'b1;
        nsel  = 3'b010;
        vsel  = 4'b1000;
        write = 1'b1;
      end
      S_MWR: begin
        msel   = 1'b1;
        mwrite = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef SEQ_HALT_INSTR_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_seq_controller.sv
// Directed vector bench for seq_controller: per-cycle expected control words.
// Define SEQ_HALT_INSTR_EN for both bench and RTL to exercise the HALT build.
module tb_seq_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       loadPC, loadIR, msel, mwrite, write;
  logic       asel, bsel, loada, loadb, loadc, loads;
  logic [3:0] vsel;
  logic [2:0] nsel;
  logic       halted;

  int compared = 0;
  int failed = 0;

  seq_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .loadPC(loadPC), .loadIR(loadIR), .msel(msel), .mwrite(mwrite),
    .write(write), .asel(asel), .bsel(bsel), .loada(loada),
    .loadb(loadb), .loadc(loadc), .loads(loads), .vsel(vsel),
    .nsel(nsel), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [18:0] outs;
  assign outs = {loadPC, loadIR, msel, mwrite, write, asel, bsel,
                 loada, loadb, loadc, loads, vsel, nsel, halted};

  localparam logic [18:0] B_LOADPC = 19'd1 << 18;
  localparam logic [18:0] B_LOADIR = 19'd1 << 17;
  localparam logic [18:0] B_MSEL   = 19'd1 << 16;
  localparam logic [18:0] B_MWRITE = 19'd1 << 15;
  localparam logic [18:0] B_WRITE  = 19'd1 << 14;
  localparam logic [18:0] B_ASEL   = 19'd1 << 13;
  localparam logic [18:0] B_BSEL   = 19'd1 << 12;
  localparam logic [18:0] B_LOADA  = 19'd1 << 11;
  localparam logic [18:0] B_LOADB  = 19'd1 << 10;
  localparam logic [18:0] B_LOADC  = 19'd1 << 9;
  localparam logic [18:0] B_LOADS  = 19'd1 << 8;
  localparam logic [18:0] V_MDATA  = 19'd1 << 7;
  localparam logic [18:0] V_IMM    = 19'd1 << 6;
  localparam logic [18:0] V_C      = 19'd1 << 4;
  localparam logic [18:0] N_RN     = 19'd1 << 3;
  localparam logic [18:0] N_RD     = 19'd1 << 2;
  localparam logic [18:0] N_RM     = 19'd1 << 1;
  localparam logic [18:0] B_HALT   = 19'd1;

  localparam logic [18:0] X_ZERO  = 19'd0;
  localparam logic [18:0] X_IF2   = B_LOADIR;
  localparam logic [18:0] X_UPD   = B_LOADPC;
  localparam logic [18:0] X_WIMM  = B_WRITE | V_IMM | N_RN;
  localparam logic [18:0] X_GETA  = B_LOADA | N_RN;
  localparam logic [18:0] X_GETB  = B_LOADB | N_RM;
  localparam logic [18:0] X_GETBS = B_LOADB | N_RD;
  localparam logic [18:0] X_EXEC  = B_LOADC;
  localparam logic [18:0] X_EXECM = B_LOADC | B_ASEL;
  localparam logic [18:0] X_EXECC = B_LOADC | B_LOADS;
  localparam logic [18:0] X_WBC   = B_WRITE | V_C | N_RD;
  localparam logic [18:0] X_ADDR  = B_BSEL | B_LOADC;
  localparam logic [18:0] X_MRD   = B_MSEL;
  localparam logic [18:0] X_LDWB  = B_MSEL | B_WRITE | V_MDATA | N_RD;
  localparam logic [18:0] X_MWR   = B_MSEL | B_MWRITE;

  typedef struct {
    logic        rst;
    logic [2:0]  opc;
    logic [1:0]  op;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic push(input logic r, input logic [2:0] c,
                      input logic [1:0] o, input logic [18:0] e);
    vec_t v;
    v.rst = r; v.opc = c; v.op = o; v.exp = e;
    vecs.push_back(v);
  endtask

  // IR is junk except on the edge leaving DEC
  task automatic fetch(input logic [2:0] c, input logic [1:0] o,
                       input logic [18:0] first);
    push(1'b0, ~c, ~o, X_IF2);
    push(1'b0, ~c, ~o, X_UPD);
    push(1'b0, ~c, ~o, X_ZERO);
    push(1'b0, c, o, first);
  endtask

  task automatic step(input logic [18:0] e);
    push(1'b0, 3'b111, 2'b11, e);
  endtask

  task automatic check(input string name, input logic [18:0] e);
    compared++;
    if (outs !== e) begin
      failed++;
      $display("FAIL %s: got %05h want %05h", name, outs, e);
    end
  endtask

  always @(negedge clk) begin
    compared++;
    if ((write && mwrite) || (loadIR && loadPC)) begin
      failed++;
      $display("FAIL excl: write=%b mwrite=%b loadIR=%b loadPC=%b want no overlap",
               write, mwrite, loadIR, loadPC);
    end
  end

  initial begin
    reset = 1'b1;
    opcode = 3'b000;
    op = 2'b00;

    push(1'b0, 3'b110, 2'b10, X_ZERO);
    fetch(3'b110, 2'b10, X_WIMM); step(X_ZERO);
    fetch(3'b110, 2'b00, X_GETB);
    step(X_EXECM); step(X_WBC); step(X_ZERO);
    fetch(3'b101, 2'b00, X_GETA);
    step(X_GETB); step(X_EXEC); step(X_WBC); step(X_ZERO);
    fetch(3'b101, 2'b10, X_GETA);
    step(X_GETB); step(X_EXEC); step(X_WBC); step(X_ZERO);
    fetch(3'b101, 2'b11, X_GETA);
    step(X_GETB); step(X_EXEC); step(X_WBC); step(X_ZERO);
    fetch(3'b101, 2'b01, X_GETA);
    step(X_GETB); step(X_EXECC); step(X_ZERO);
    fetch(3'b011, 2'b00, X_GETA);
    step(X_ADDR); step(X_MRD); step(X_LDWB); step(X_ZERO);
    fetch(3'b100, 2'b00, X_GETA);
    step(X_ADDR); step(X_GETBS); step(X_MWR); step(X_ZERO);
    fetch(3'b000, 2'b00, X_ZERO);
    fetch(3'b110, 2'b01, X_ZERO);
    fetch(3'b011, 2'b01, X_ZERO);
    fetch(3'b100, 2'b11, X_ZERO);
`ifdef SEQ_HALT_INSTR_EN
    fetch(3'b111, 2'b01, B_HALT);
    for (int k = 0; k < 22; k++) step(B_HALT);
`else
    fetch(3'b111, 2'b01, X_ZERO);
    fetch(3'b110, 2'b10, X_WIMM); step(X_ZERO);
`endif

    @(posedge clk); #1;
    check("reset_state", X_ZERO);
    @(posedge clk); #1;
    check("reset_hold", X_ZERO);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      opcode = vecs[i].opc;
      op = vecs[i].op;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset from wherever the table left the FSM
    #2 reset = 1'b1;
    #1 check("async_rst_idle", X_ZERO);
    @(posedge clk); #1;
    check("rst_held", X_ZERO);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rel_if1", X_ZERO);
    @(posedge clk); #1;
    check("rel_if2", X_IF2);
    @(posedge clk); #1;
    check("add_upd", X_UPD);
    opcode = 3'b101; op = 2'b00;
    @(posedge clk); #1;
    check("add_dec", X_ZERO);
    @(posedge clk); #1;
    check("add_geta", X_GETA);
    opcode = 3'b000;
    @(posedge clk); #1;
    check("add_getb", X_GETB);
    #2 reset = 1'b1;
    #1 check("async_rst_getb", X_ZERO);
    @(posedge clk); #1;
    check("no_wbc_1", X_ZERO);
    @(posedge clk); #1;
    check("no_wbc_2", X_ZERO);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_if1", X_ZERO);
    @(posedge clk); #1;
    check("post_rst_if2", X_IF2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 SHALL have ports in this order: clk, reset, opcode, op, then outputs.
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high; forces the RESET state immediately.
REQ-004 opcode  in  3  IR[15:13] from instruction register.
REQ-005 op  in  2  IR[12:11] from instruction register.
REQ-006 loadPC, loadIR, msel, mwrite, write, asel, bsel, loada, loadb, loadc, loads  out  1 each  datapath controls.
REQ-007 msel: 0 = memory address from PC; 1 = memory address from C.
REQ-008 vsel  out  4  one-hot writeback select: [3] mdata, [2] sximm8, [1] PC, [0] C; 0000 when write=0.
REQ-009 nsel  out  3  one-hot register select: [2] Rn, [1] Rd, [0] Rm; 000 when no register access.
REQ-010 halted  out  1  high while in the HALT state.
REQ-011 ALUop and shift SHALL NOT be driven by this block; the decoder drives them from IR.

Function
REQ-012 SHALL be a Moore FSM; all outputs decode from the registered state only.
REQ-013 Any output not listed for a state SHALL be 0 in that state.
REQ-014 States and outputs:
- RESET: none.
- IF1: msel=0.
- IF2: msel=0, loadIR=1.
- UPD: loadPC=1.
- DEC: none.
- WIMM: nsel=Rn, vsel=0100, write=1.
- GETA: nsel=Rn, loada=1.
- GETB: nsel=Rm, loadb=1; for STR, nsel=Rd.
- EXEC: asel=1 for MOV-reg else 0, bsel=0, loadc=1; loads=1 only for CMP.
- WBC: nsel=Rd, vsel=0001, write=1.
- ADDR: asel=0, bsel=1, loadc=1.
- MRD: msel=1.
- LDWB: msel=1, nsel=Rd, vsel=1000, write=1.
- MWR: msel=1, mwrite=1.
- HALT: halted=1.
REQ-015 Fetch path: RESET->IF1->IF2->UPD->DEC, one state per cycle.
REQ-016 DEC branches on {opcode,op}:
- 110_10 MOV imm: WIMM->IF1.
- 110_00 MOV reg: GETB->EXEC->WBC->IF1.
- 101_00 ADD, 101_10 AND, 101_11 MVN: GETA->GETB->EXEC->WBC->IF1.
- 101_01 CMP: GETA->GETB->EXEC->IF1 (no writeback).
- 011_00 LDR: GETA->ADDR->MRD->LDWB->IF1.
- 100_00 STR: GETA->ADDR->GETB->MWR->IF1.
REQ-017 The decoder SHALL present ALUop=00 (ADD) for LDR/STR via op=00; this block relies on that.
REQ-018 Any other {opcode,op} SHALL return DEC->IF1 with no register or memory write.
REQ-019 Latency from IF1 to the next IF1: MOV imm 5 cycles; MOV reg and CMP 7; ADD/AND/MVN, LDR and STR 8.
REQ-020 opcode and op SHALL be sampled only in DEC; changes at other times SHALL have no effect.
REQ-021 write and mwrite SHALL never be high in the same cycle; loadIR and loadPC SHALL never be high in the same cycle.

Reset
REQ-022 reset high SHALL force the RESET state asynchronously, with all outputs 0, from any state including mid-instruction and HALT.
REQ-023 The first rising clk edge after reset deasserts SHALL move RESET->IF1.

Configuration
REQ-024 With macro SEQ_HALT_INSTR_EN defined, {opcode=111, any op} in DEC SHALL go to HALT, which persists until reset.
REQ-025 Without SEQ_HALT_INSTR_EN, opcode 111 SHALL be treated as illegal per REQ-018, the HALT state SHALL not exist, and halted SHALL be tied 0.

Verification
REQ-026 Release reset, IR=16'hD105 (MOV R1,#5) -> IF2 loadIR=1 at edge 2, loadPC=1 at edge 3, WIMM write=1 vsel=0100 nsel=100 at edge 5, IF1 at edge 6.
REQ-027 IR=16'hA0A2 (ADD) -> GETA loada=1/nsel=100, GETB loadb=1/nsel=001, EXEC loadc=1 loads=0, WBC vsel=0001 nsel=010; total 8 cycles.
REQ-028 IR op=01 (CMP, opcode 101) -> EXEC loads=1, no cycle with write=1; back to IF1 after 7 cycles.
REQ-029 LDR then STR -> LDWB vsel=1000 msel=1 write=1; MWR mwrite=1 msel=1 write=0; each takes 8 cycles.
REQ-030 Assert reset during GETB of ADD -> all outputs 0 in the same cycle; no WBC occurs; IF1 follows the first edge after release.
REQ-031 With SEQ_HALT_INSTR_EN, opcode 111 -> halted=1 held for 20+ cycles with all other outputs 0; without it, opcode 111 returns to IF1 after DEC.
